rtype_control_sequencer: RTL

- Control-side counterpart of the register-file/ALU datapath.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes R-type (opcode 0110011) fields.
- Sequences datapath control (read_reg_num1/2, write_reg, alu_control, regwrite) through a multi-cycle FSM, then captures the datapath zero_flag.
- Sits between the instruction source (fetch stage or test driver) and the datapath.

---
 rtl/rtype_control_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rtype_control_sequencer.sv
// ============================================================================
// Module      : rtype_control_sequencer
// Description : Multi-cycle RV32I R-type control sequencer (IDLE/DECODE/EXEC/DONE).
//               SEQ_PERF_CNT_EN adds retired/illegal instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtype_control_sequencer
`ifdef SEQ_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inst_valid,
    input  logic [31:0]      inst_data,
    output logic             inst_ready,
    input  logic             zero_flag,
    output logic [4:0]       read_reg_num1,
    output logic [4:0]       read_reg_num2,
    output logic [4:0]       write_reg,
    output logic [3:0]       alu_control,
    output logic             regwrite,
    output logic             done,
    output logic             illegal,
`ifdef SEQ_PERF_CNT_EN
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
`endif
    output logic             last_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;

    state_t     state_q;
    logic [4:0] rs1_q, rs2_q, rd_q;
    logic [3:0] alu_q;
    logic       legal_q, regwrite_q, done_q, illegal_q, last_zero_q;
    logic [3:0] alu_d;
    logic       legal_d;
`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_q, illegal_cnt_q;
`endif

    // Decoded straight off the bus so the DECODE cycle already shows the fields.
    always_comb begin
        alu_d   = 4'b0000;
        legal_d = 1'b1;
        case ({inst_data[31:25], inst_data[14:12]})
            10'b0000000_000: alu_d = 4'b0010;
            10'b0100000_000: alu_d = 4'b0110;
            10'b0000000_001: alu_d = 4'b1000;
            10'b0000000_010: alu_d = 4'b0111;
            10'b0000000_011: alu_d = 4'b1011;
            10'b0000000_100: alu_d = 4'b0100;
            10'b0000000_101: alu_d = 4'b1001;
            10'b0100000_101: alu_d = 4'b1010;
            10'b0000000_110: alu_d = 4'b0001;
            10'b0000000_111: alu_d = 4'b0000;
            default:         legal_d = 1'b0;
        endcase
        if (inst_data[6:0] != C_OP_RTYPE) begin
            legal_d = 1'b0;
        end
        if (!legal_d) begin
            alu_d = 4'b0000;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            alu_q       <= 4'b0000;
            legal_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            last_zero_q <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst_valid) begin
                        rs1_q   <= inst_data[19:15];
                        rs2_q   <= inst_data[24:20];
                        rd_q    <= inst_data[11:7];
                        alu_q   <= alu_d;
                        legal_q <= legal_d;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    regwrite_q <= legal_q && (rd_q != 5'd0);
                    state_q    <= S_EXEC;
                end
                S_EXEC: begin
                    regwrite_q <= 1'b0;
                    done_q     <= 1'b1;
                    illegal_q  <= !legal_q;
                    if (legal_q) begin
                        last_zero_q <= zero_flag;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
`ifdef SEQ_PERF_CNT_EN
                    if (legal_q) begin
                        retired_cnt_q <= retired_cnt_q + 1'b1;
                    end else begin
                        illegal_cnt_q <= illegal_cnt_q + 1'b1;
                    end
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign inst_ready    = (state_q == S_IDLE);
    assign read_reg_num1 = rs1_q;
    assign read_reg_num2 = rs2_q;
    assign write_reg     = rd_q;
    assign alu_control   = alu_q;
    assign regwrite      = regwrite_q;
    assign done          = done_q;
    assign illegal       = illegal_q;
    assign last_zero     = last_zero_q;
`ifdef SEQ_PERF_CNT_EN
    assign retired_cnt   = retired_cnt_q;
    assign illegal_cnt   = illegal_cnt_q;
`endif

endmodule

`default_nettype wire
